fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if.sv | 40 ++++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FETCH_MISALIGN_EN adds a misalign flag to each queue entry.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

`ifdef FETCH_MISALIGN_EN
  localparam int ENTRY_W = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;
`else
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
`endif

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect input, decode-side valid/ready, instruction-memory port.
// FETCH_MISALIGN_EN adds out_misalign.
interface fetch_if #(
  parameter int IM_AW = 10
);

  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
`ifdef FETCH_MISALIGN_EN
  logic             out_misalign;
`endif
  logic             im_req;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;

`ifdef FETCH_MISALIGN_EN
  modport master (
    input  redirect, redirect_pc, out_ready, im_rdata,
    output out_valid, out_pc, out_instr, out_misalign, im_req, im_addr
  );
  modport slave (
    output redirect, redirect_pc, out_ready, im_rdata,
    input  out_valid, out_pc, out_instr, out_misalign, im_req, im_addr
  );
`else
  modport master (
    input  redirect, redirect_pc, out_ready, im_rdata,
    output out_valid, out_pc, out_instr, im_req, im_addr
  );
  modport slave (
    output redirect, redirect_pc, out_ready, im_rdata,
    input  out_valid, out_pc, out_instr, im_req, im_addr
  );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush. Pointers carry an extra wrap bit
// so full/empty come from a plain pointer compare.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = ENTRY_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign wr_en = push && (flush || !full);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      // A push arriving with a flush becomes the sole surviving entry.
      rd_ptr <= '0;
      wr_ptr <= push ? (AW+1)'(1) : '0;
    end else begin
      if (wr_en)          wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[flush ? (AW)'(0) : wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with prefetch queue, credit-based issue and redirect flush.
// FETCH_MISALIGN_EN: misaligned redirect enqueues one flagged entry and idles fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4,
  parameter int          IM_AW    = 10
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          issue;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          idle;
  logic          bad_target;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

`ifdef FETCH_MISALIGN_EN
  assign bad_target = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst)               idle <= 1'b0;
    else if (bus.redirect) idle <= bad_target;
  end
`else
  assign bad_target = 1'b0;
  assign idle       = 1'b0;
`endif

  // The in-flight read holds a queue slot, so a returning word always fits.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = !rst && !bus.redirect && !idle && !full && (credit_used < (CW+1)'(DEPTH));
  assign push  = (inflight && !bus.redirect) || bad_target;
  assign pop   = bus.out_ready && !empty && !bus.redirect;

  always_comb begin
    // NOTE: default every field first so no path leaves push_entry unassigned (no latch).
    push_entry       = '0;
    push_entry.pc    = inflight_pc;
    push_entry.instr = bus.im_rdata;
    if (bad_target) begin
      push_entry.pc    = bus.redirect_pc;
      push_entry.instr = INSTR_NOP;
    end
`ifdef FETCH_MISALIGN_EN
    push_entry.misalign = bad_target;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign bus.im_req    = issue;
  assign bus.im_addr   = fetch_pc[IM_AW+1:2];
  assign bus.out_valid = !empty;
  assign bus.out_pc    = empty ? '0 : head.pc;
  assign bus.out_instr = empty ? '0 : head.instr;
`ifdef FETCH_MISALIGN_EN
  assign bus.out_misalign = !empty && head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected entries, a monitor
// compares every accepted head against them.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int IM_AW = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_if #(.IM_AW(IM_AW)) bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .DEPTH    (4),
    .IM_AW    (IM_AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t expq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [31:0] instr_of(input logic [IM_AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.im_req) bus.im_rdata <= instr_of(bus.im_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic mis);
    exp_t e;
    e.pc    = pc;
    e.instr = mis ? 32'h0 : instr_of(pc[IM_AW+1:2]);
    e.mis   = mis;
    expq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready && !bus.redirect) begin
        if (expq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pop: got pc 0x%08h, expected no entry", bus.out_pc);
        end else begin
          e = expq.pop_front();
          check("sb_pc", bus.out_pc, e.pc);
          check("sb_instr", bus.out_instr, e.instr);
`ifdef FETCH_MISALIGN_EN
          check("sb_misalign", bus.out_misalign, e.mis);
`endif
        end
      end
    end
  end

  initial begin
    int nreq;
    int gaps;
    rst = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_im_req", bus.im_req, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_instr", bus.out_instr, 0);
    cyc();

    // Streaming from reset with out_ready=1.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) expect_entry(32'h3000 + 32'(4 * i), 1'b0);
    @(negedge clk);
    check("p1_c0_req", bus.im_req, 1);
    check("p1_c0_addr", bus.im_addr, 10'h000);
    check("p1_c0_valid", bus.out_valid, 0);
    cyc();
    @(negedge clk);
    check("p1_c1_addr", bus.im_addr, 10'h001);
    check("p1_c1_valid", bus.out_valid, 0);
    cyc();
    repeat (6) cyc();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    check("p1_all_seen", expq.size(), 0);

    // Reset mid-operation discards queue and in-flight read.
    cyc();
    @(negedge clk);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_req", bus.im_req, 0);
    check("midrst_pc", bus.out_pc, 0);
    cyc();

    // Backpressure: exactly DEPTH requests, then stall with a stable head.
    rst  = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.im_req) begin
        check($sformatf("p2_addr%0d", nreq), bus.im_addr, 32'(nreq));
        nreq++;
      end
      cyc();
    end
    check("p2_nreq", nreq, 4);
    @(negedge clk);
    check("p2_full_req", bus.im_req, 0);
    check("p2_head_valid", bus.out_valid, 1);
    check("p2_head_pc", bus.out_pc, 32'h3000);
    check("p2_head_instr", bus.out_instr, 32'hC0DE_0000);
    cyc();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) expect_entry(32'h3000 + 32'(4 * i), 1'b0);
    gaps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.out_valid) gaps++;
      cyc();
    end
    bus.out_ready = 1'b0;
    rst = 1'b1;
    check("p2_no_gap", gaps, 0);
    check("p2_all_seen", expq.size(), 0);
    cyc();
    cyc();

    // Redirect with 3 queued entries and one read in flight.
    rst = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("p3_last_req", bus.im_req, 1);
    check("p3_last_addr", bus.im_addr, 10'h003);
    cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3400;
    @(negedge clk);
    check("p3_pre_valid", bus.out_valid, 1);
    check("p3_redir_req", bus.im_req, 0);
    cyc();
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b1;
    expect_entry(32'h3400, 1'b0);
    expect_entry(32'h3404, 1'b0);
    expect_entry(32'h3408, 1'b0);
    @(negedge clk);
    check("p3_flush_valid", bus.out_valid, 0);
    check("p3_tgt_req", bus.im_req, 1);
    check("p3_tgt_addr", bus.im_addr, 10'h100);
    cyc();
    @(negedge clk);
    check("p3_lat_valid", bus.out_valid, 0);
    cyc();
    cyc();
    cyc();
    cyc();

    // Redirect coinciding with a pop and a returning word.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3800;
    @(negedge clk);
    check("p4_pre_valid", bus.out_valid, 1);
    check("p4_redir_req", bus.im_req, 0);
    cyc();
    bus.redirect = 1'b0;
    check("p4_seen", expq.size(), 0);
    expect_entry(32'h3800, 1'b0);
    expect_entry(32'h3804, 1'b0);
    @(negedge clk);
    check("p4_flush_valid", bus.out_valid, 0);
    check("p4_tgt_req", bus.im_req, 1);
    check("p4_tgt_addr", bus.im_addr, 10'h200);
    cyc();
    @(negedge clk);
    check("p4_lat_valid", bus.out_valid, 0);
    cyc();
    cyc();
    cyc();

    // Back-to-back redirects, the last one targeting the top of the address space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_5000;
    cyc();
    bus.redirect_pc = 32'hFFFF_FFFC;
    check("p5_seen", expq.size(), 0);
    @(negedge clk);
    check("p5_b2b_req", bus.im_req, 0);
    cyc();
    bus.redirect = 1'b0;
    expect_entry(32'hFFFF_FFFC, 1'b0);
    expect_entry(32'h0000_0000, 1'b0);
    @(negedge clk);
    check("p5_req", bus.im_req, 1);
    check("p5_addr_hi", bus.im_addr, 10'h3FF);
    check("p5_valid", bus.out_valid, 0);
    cyc();
    @(negedge clk);
    check("p5_addr_lo", bus.im_addr, 10'h000);
    check("p5_lat_valid", bus.out_valid, 0);
    cyc();
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    check("p5_wrap_seen", expq.size(), 0);

    // Redirect with a misaligned target.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3402;
    cyc();
    bus.redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
    @(negedge clk);
    check("mis_valid", bus.out_valid, 1);
    check("mis_pc", bus.out_pc, 32'h3402);
    check("mis_instr", bus.out_instr, 32'h0);
    check("mis_flag", bus.out_misalign, 1);
    check("mis_req", bus.im_req, 0);
    cyc();
    @(negedge clk);
    check("mis_idle_req", bus.im_req, 0);
    check("mis_hold_pc", bus.out_pc, 32'h3402);
    cyc();
    bus.out_ready = 1'b1;
    expect_entry(32'h3402, 1'b1);
    cyc();
    check("mis_seen", expq.size(), 0);
    @(negedge clk);
    check("mis_empty_valid", bus.out_valid, 0);
    check("mis_still_idle", bus.im_req, 0);
    cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3000;
    cyc();
    bus.redirect = 1'b0;
    expect_entry(32'h3000, 1'b0);
    @(negedge clk);
    check("mis_resume_req", bus.im_req, 1);
    check("mis_resume_addr", bus.im_addr, 10'h000);
    cyc();
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    check("mis_resume_seen", expq.size(), 0);
`else
    @(negedge clk);
    check("mask_req", bus.im_req, 1);
    check("mask_addr", bus.im_addr, 10'h100);
    check("mask_valid", bus.out_valid, 0);
    cyc();
    cyc();
    bus.out_ready = 1'b1;
    expect_entry(32'h3400, 1'b0);
    cyc();
    bus.out_ready = 1'b0;
    check("mask_seen", expq.size(), 0);
`endif

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
